// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_arb_state_t;

  localparam int UART_CLK_DIVIDER = 104;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker with optional single-owner lock.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          lock_en,
  input  logic [PW-1:0] lock_id,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [N-1:0]  w_cand;
  logic [PW-1:0] w_idx;

  always_comb begin
    w_cand = req;
    if (lock_en) begin
      w_cand = req & (N'(1) << lock_id);
    end
  end

  // Search upward from ptr, wrapping; the first candidate found wins.
  always_comb begin
    w_idx       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_idx = PW'((int'(ptr) + i) % N);
      if (!grant_valid && w_cand[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
    grant = grant_valid ? (N'(1) << grant_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one uart_tx among NUM_REQ byte sources.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_PACKETS = 1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 txdata_valid_o,
  output logic [7:0]           txdata_o,
  input  logic                 uart_busy_i,
  output logic                 active_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  localparam logic [1:0]    c_st_idle      = IDLE;
  localparam logic [1:0]    c_st_issue     = ISSUE;
  localparam logic [1:0]    c_st_wait_busy = WAIT_BUSY;
  localparam logic [1:0]    c_st_wait_done = WAIT_DONE;
  localparam logic [CW-1:0] c_cnt_last     = CW'(BUSY_TIMEOUT - 1);
  localparam logic [PW-1:0] c_ptr_last     = PW'(NUM_REQ - 1);

  logic [1:0]         r_state;
  logic [PW-1:0]      r_ptr;
  logic               r_lock_en;
  logic [PW-1:0]      r_lock_id;
  logic               r_last;
  logic [NUM_REQ-1:0] r_grant;
  uart_byte_t         r_txdata;
  logic [CW-1:0]      r_cnt;

  logic [NUM_REQ-1:0] w_win;
  logic [PW-1:0]      w_win_idx;
  logic               w_win_valid;
  logic               w_accept;
  uart_byte_t         w_win_byte;
  logic               w_win_last;
  logic               w_lock_next;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req         (req_valid_i),
    .ptr         (r_ptr),
    .lock_en     (r_lock_en),
    .lock_id     (r_lock_id),
    .grant       (w_win),
    .grant_idx   (w_win_idx),
    .grant_valid (w_win_valid)
  );

  assign w_accept    = (r_state == c_st_idle) && w_win_valid && !uart_busy_i;
  assign w_win_byte  = req_data_i[{w_win_idx, 3'b000} +: 8];
  assign w_win_last  = req_last_i[w_win_idx];
  assign w_lock_next = (LOCK_PACKETS != 0) && !w_win_last;

  // Ready is gated by reset so that every output reads 0 while reset is held.
  assign req_ready_o    = (w_accept && !reset_i) ? w_win : '0;
  assign grant_o        = r_grant;
  assign txdata_valid_o = (r_state == c_st_issue);
  assign txdata_o       = r_txdata;
  assign active_o       = (r_state != c_st_idle);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= c_st_idle;
      r_ptr     <= '0;
      r_lock_en <= 1'b0;
      r_lock_id <= '0;
      r_last    <= 1'b0;
      r_grant   <= '0;
      r_txdata  <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_txdata  <= w_win_byte;
            r_last    <= w_win_last;
            r_grant   <= w_win;
            r_ptr     <= (w_win_idx == c_ptr_last) ? '0 : w_win_idx + PW'(1);
            r_lock_en <= w_lock_next;
            r_lock_id <= w_win_idx;
            r_state   <= c_st_issue;
          end
        end
        c_st_issue: begin
          r_cnt   <= '0;
          r_state <= c_st_wait_busy;
        end
        c_st_wait_busy: begin
          if (uart_busy_i) begin
            r_state <= c_st_wait_done;
          end else if (r_cnt == c_cnt_last) begin
            // uart_tx never went busy: it dropped the strobe, so send it again.
            r_state <= c_st_issue;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        c_st_wait_done: begin
          if (!uart_busy_i) begin
            r_state <= c_st_idle;
            if (!((LOCK_PACKETS != 0) && !r_last)) begin
              r_grant <= '0;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire
